// File: rtl/red_unit.sv
// red_unit: multi-cycle reduction for the RED instruction.
// Produces the sign-extended sum of the four signed bytes of rs and rt:
//   rs[15:8] + rt[15:8] + rs[7:0] + rt[7:0]
// A single shared red_add16 slice performs every addition, sequenced
// by the FSM: IDLE -> LO -> HI -> SUM -> DONE.
// Optional macro: RED_FLAGS_EN adds the registered flag_z / flag_n outputs.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (rs, rt)
//   flush               synchronous abort to IDLE
//   out_valid/out_ready result handshake (result[15:0])
//   flag_z, flag_n      result==0 / result sign (RED_FLAGS_EN only)

// Nonsaturating 16-bit adder slice; carry-out is dropped.
module red_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  assign sum = a + b;
endmodule

module red_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] rs,
  input  logic [15:0] rt,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result
`ifdef RED_FLAGS_EN
  ,
  output logic        flag_z,
  output logic        flag_n
`endif
);

  typedef enum logic [2:0] {IDLE, LO, HI, SUM, DONE} state_t;

  typedef struct packed {
    logic [15:0] rs;
    logic [15:0] rt;
  } red_req_t;

  state_t      state;
  red_req_t    req_r;
  logic [8:0]  lo_r, hi_r;
  logic [15:0] result_r;
  logic [15:0] add_a, add_b, add_sum;

  // Operand select for the shared adder. Bytes and partial sums are
  // sign-extended to 16 bits; byte sums fit in 9 bits and the final sum
  // in 10, so the low bits of the 16-bit sum are exact.
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      LO: begin
        add_a = {{8{req_r.rs[7]}},  req_r.rs[7:0]};
        add_b = {{8{req_r.rt[7]}},  req_r.rt[7:0]};
      end
      HI: begin
        add_a = {{8{req_r.rs[15]}}, req_r.rs[15:8]};
        add_b = {{8{req_r.rt[15]}}, req_r.rt[15:8]};
      end
      SUM: begin
        add_a = {{7{lo_r[8]}}, lo_r};
        add_b = {{7{hi_r[8]}}, hi_r};
      end
      default: ;
    endcase
  end

  red_add16 u_add (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_r    <= '0;
      lo_r     <= '0;
      hi_r     <= '0;
      result_r <= '0;
`ifdef RED_FLAGS_EN
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
`endif
    end else if (flush) begin
      // Abort wins over any same-cycle accept or result handshake.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          req_r <= '{rs: rs, rt: rt};
          state <= LO;
        end
        LO: begin
          lo_r  <= add_sum[8:0];
          state <= HI;
        end
        HI: begin
          hi_r  <= add_sum[8:0];
          state <= SUM;
        end
        SUM: begin
          result_r <= add_sum;
`ifdef RED_FLAGS_EN
          flag_z   <= (add_sum == 16'h0000);
          flag_n   <= add_sum[15];
`endif
          state    <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode from state only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_r;

endmodule

// File: tb/tb_red_unit.sv
// Directed bench for red_unit: reset, arithmetic extremes, latency,
// backpressure, flush and asynchronous reset.
module tb_red_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] rs, rt;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
`ifdef RED_FLAGS_EN
  logic        flag_z, flag_n;
`endif

  int passed = 0;
  int total  = 0;

  red_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs        (rs),
    .rt        (rt),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef RED_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_n    (flag_n)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
  endtask

  task automatic check_flags(input string tag, input logic z, input logic n);
`ifdef RED_FLAGS_EN
    check({tag, "_z"}, {15'd0, flag_z}, {15'd0, z});
    check({tag, "_n"}, {15'd0, flag_n}, {15'd0, n});
`else
    if (z === n) begin end  // flags absent in this build
`endif
  endtask

  // Accept one op, wait for out_valid (bounded), check latency and result.
  task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp);
    int n;
    check({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
    in_valid = 1'b1; rs = a; rt = b;
    tick();
    in_valid = 1'b0;
    rs = 16'hA5A5; rt = 16'h5A5A;  // must not disturb the captured operands
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n[15:0], 16'd3);
    check({tag, "_result"}, result, exp);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_done_ov"}, {15'd0, out_valid}, 16'd0);
    check({tag, "_done_ir"}, {15'd0, in_ready}, 16'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; rs = '0; rt = '0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_in_ready",  {15'd0, in_ready},  16'd1);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_result",    result,             16'h0000);
    check_flags("rst", 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", {15'd0, in_ready}, 16'd1);

    // 127*4 = 508
    start_op("pos", 16'h7F7F, 16'h7F7F, 16'h01FC);
    check_flags("pos", 1'b0, 1'b0);
    finish_op("pos");

    // -128*4 = -512
    start_op("neg", 16'h8080, 16'h8080, 16'hFE00);
    check_flags("neg", 1'b0, 1'b1);
    finish_op("neg");

    // 1+2+3+4 = 10
    start_op("mix", 16'h0102, 16'h0304, 16'h000A);
    check_flags("mix", 1'b0, 1'b0);
    finish_op("mix");

    // -1+1+1-1 = 0
    start_op("zero", 16'hFF01, 16'h01FF, 16'h0000);
    check_flags("zero", 1'b1, 1'b0);
    finish_op("zero");

    // Backpressure: result held, new request ignored.
    out_ready = 1'b0;
    start_op("bp", 16'h7F7F, 16'h7F7F, 16'h01FC);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; rs = 16'h0101; rt = 16'h0101;
      tick();
      check("bp_out_valid", {15'd0, out_valid}, 16'd1);
      check("bp_in_ready",  {15'd0, in_ready},  16'd0);
      check("bp_result",    result,             16'h01FC);
    end
    in_valid = 1'b0;
    finish_op("bp");
    tick();
    check("bp_no_ghost", {15'd0, in_ready}, 16'd1);

    // Flush while in HI.
    in_valid = 1'b1; rs = 16'h0102; rt = 16'h0304;
    tick();             // LO
    in_valid = 1'b0;
    tick();             // HI
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_in_ready",  {15'd0, in_ready},  16'd1);
    check("fl_out_valid", {15'd0, out_valid}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fl_no_valid", {15'd0, out_valid}, 16'd0);
    end

    // Asynchronous reset mid-SUM (result register holds 0x01FC before it).
    in_valid = 1'b1; rs = 16'h8080; rt = 16'h8080;
    tick();             // LO
    in_valid = 1'b0;
    tick();             // HI
    tick();             // SUM
    rst_n = 1'b0;
    #1;
    check("ar_in_ready",  {15'd0, in_ready},  16'd1);
    check("ar_out_valid", {15'd0, out_valid}, 16'd0);
    check("ar_result",    result,             16'h0000);
    check_flags("ar", 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    start_op("post", 16'h0102, 16'h0304, 16'h000A);
    finish_op("post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/red_unit.md
# red_unit

Multi-cycle reduction unit for the RED instruction in the execute stage. It accepts two 16-bit register operands and produces the sign-extended sum of all four signed bytes: rs[15:8] + rt[15:8] + rs[7:0] + rt[7:0]. It uses a valid/ready handshake on both sides. The ALU result mux consumes its output and stalls on it, and the block reuses the team's nonsaturating 16-bit adder slice for every addition.

## Interface
Parameters:
- none.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands present on rs/rt.
- in_ready  output  1  unit can accept an operation.
- rs  input  16  first operand.
- rt  input  16  second operand.
- flush  input  1  synchronous abort from hazard/branch logic.
- out_valid  output  1  result holds a completed reduction.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  16  sign-extended reduction sum.
- flag_z  output  1  result == 0. Present only with RED_FLAGS_EN.
- flag_n  output  1  result[15]. Present only with RED_FLAGS_EN.

## Operation
- FSM states: IDLE, LO, HI, SUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch rs/rt into operand registers and go to LO.
- LO: lo_r (9-bit) <= sext9(rs_r[7:0]) + sext9(rt_r[7:0]); go to HI.
- HI: hi_r (9-bit) <= sext9(rs_r[15:8]) + sext9(rt_r[15:8]); go to SUM.
- SUM: result_r <= sext16(sext10(lo_r) + sext10(hi_r)); go to DONE.
- DONE:
  - out_valid=1.
  - result_r, and the flags when enabled, are held stable until out_ready=1.
  - Then go to IDLE.
- Arithmetic width rules:
  - Byte sums are exact at 9 bits; range -256..254.
  - The final sum is exact at 10 bits; range -512..508.
  - No saturation and no overflow output.
- in_ready is asserted only in IDLE. There is no overlap: a new operation is accepted no earlier than the cycle after the DONE handshake.
- in_valid is ignored outside IDLE. Operands are captured once, so later changes on rs/rt have no effect on an operation in flight.
- flush:
  - From any state, go to IDLE at the next edge.
  - Drop out_valid and discard the partial result.
  - flush overrides a same-cycle in_valid accept and a same-cycle DONE handshake; the result is treated as not delivered.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0x0000, lo_r/hi_r/operand registers=0, flag_z=0, flag_n=0.
- Reset asserted mid-operation returns everything to reset values immediately, asynchronously.

## Timing
- Accept edge T0 (in_valid & in_ready).
  - LO at T0..T1, HI at T1..T2, SUM at T2..T3.
  - out_valid=1 after edge T3.
  - Latency is 3 cycles from accept to out_valid.
- With out_ready tied high:
  - DONE lasts exactly one cycle; in_ready is high again after edge T4.
  - Throughput is one operation per 5 cycles.
- All outputs are registered or decoded from FSM state only. There is no combinational path from any input to any output.

## Configuration
- RED_FLAGS_EN defined:
  - flag_z and flag_n ports exist.
  - They are registered in the SUM->DONE transition together with result and held with it.
  - They reset to 0.
- RED_FLAGS_EN undefined:
  - Ports and flag registers are absent.
  - All other behaviour and timing are identical.

## Test plan
- Reset then idle: rst_n low, then high -> in_ready=1, out_valid=0, result=0x0000, flags 0.
- Positive extreme: rs=0x7F7F, rt=0x7F7F, out_ready=1 -> out_valid exactly 3 cycles after accept, result=0x01FC, flag_n=0, flag_z=0.
- Negative extreme: rs=0x8080, rt=0x8080 -> result=0xFE00, flag_n=1, flag_z=0.
- Mixed and zero: rs=0x0102, rt=0x0304 -> 0x000A. Then rs=0xFF01, rt=0x01FF -> 0x0000 with flag_z=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0, new in_valid ignored.
  - Release out_ready -> one handshake, then in_ready=1 next cycle.
- Abort and reset:
  - flush in HI -> IDLE next cycle with out_valid never asserted.
  - rst_n pulsed low mid-SUM -> immediate reset values.
  - A following op rs=0x0102, rt=0x0304 still returns 0x000A.
